// File: rtl/set_assoc_cache_if.sv
// Bus interfaces of set_assoc_cache: the valid/ready CPU port and the word-serial memory port.
// Each carries a master and a slave modport.
interface cache_cpu_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic              cpu_req_we;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic [DATA_W-1:0] cpu_req_wdata;
  logic              cpu_resp_valid;
  logic [DATA_W-1:0] cpu_resp_rdata;
  logic              cpu_resp_hit;

  modport master (
    output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, cpu_resp_hit
  );
  modport slave (
    input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, cpu_resp_hit
  );
endinterface

interface cache_mem_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_ack, mem_rdata
  );
  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back cache with line bursts, invalid-first/LRU victim choice.
// Define CACHE_STATS_EN to build the hit/miss statistics counters.
module set_assoc_cache #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int SETS       = 64,
  parameter int WAYS       = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  cache_cpu_if.slave  cpu,
  cache_mem_if.master mem,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_WRITEBACK = 3'd2;
  localparam logic [2:0] S_REFILL    = 3'd3;
  localparam logic [2:0] S_RESPOND   = 3'd4;

  localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(LINE_WORDS - 1);
  localparam logic [WAY_W-1:0] AGE_MAX  = WAY_W'(WAYS - 1);

  logic [2:0]        state_r;
  logic              req_we_r;
  logic [ADDR_W-1:0] req_addr_r;
  logic [DATA_W-1:0] req_wdata_r;
  logic              miss_r;
  logic [WAY_W-1:0]  victim_r;
  logic [OFF_W-1:0]  cnt_r;
  logic              resp_valid_r;
  logic              resp_hit_r;
  logic [DATA_W-1:0] resp_rdata_r;
  logic              mem_valid_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;

  logic [TAG_W-1:0]  tag_r   [SETS][WAYS];
  logic [DATA_W-1:0] data_r  [SETS][WAYS][LINE_WORDS];
  logic [WAYS-1:0]   valid_r [SETS];
  logic [WAYS-1:0]   dirty_r [SETS];
  logic [WAY_W-1:0]  age_r   [SETS][WAYS];

  logic [OFF_W-1:0]  off_s;
  logic [IDX_W-1:0]  idx_s;
  logic [TAG_W-1:0]  tag_s;
  logic [OFF_W-1:0]  cnt_nxt_s;
  logic              ack_s;
  logic              hit_s;
  logic [WAY_W-1:0]  hit_way_s;
  logic              inv_found_s;
  logic [WAY_W-1:0]  inv_way_s;
  logic [WAY_W-1:0]  lru_way_s;
  logic [WAY_W-1:0]  victim_s;

  assign off_s     = req_addr_r[OFF_W-1:0];
  assign idx_s     = req_addr_r[OFF_W +: IDX_W];
  assign tag_s     = req_addr_r[ADDR_W-1 -: TAG_W];
  assign cnt_nxt_s = cnt_r + {{(OFF_W-1){1'b0}}, 1'b1};
  assign ack_s     = mem.mem_ack && mem_valid_r;

  // Tag match plus victim choice; the descending scan leaves the lowest-index invalid way.
  always_comb begin
    hit_s       = 1'b0;
    hit_way_s   = {WAY_W{1'b0}};
    inv_found_s = 1'b0;
    inv_way_s   = {WAY_W{1'b0}};
    lru_way_s   = {WAY_W{1'b0}};
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_r[idx_s][w]) begin
        inv_found_s = 1'b1;
        inv_way_s   = WAY_W'(w);
      end else if (tag_r[idx_s][w] == tag_s) begin
        hit_s     = 1'b1;
        hit_way_s = WAY_W'(w);
      end else begin
        hit_s = hit_s;
      end
      if (age_r[idx_s][w] == {WAY_W{1'b0}}) begin
        lru_way_s = WAY_W'(w);
      end else begin
        lru_way_s = lru_way_s;
      end
    end
    victim_s = inv_found_s ? inv_way_s : lru_way_s;
  end

  // Miss FSM, request capture, response and memory-port registers, valid/dirty/LRU state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      req_we_r     <= 1'b0;
      req_addr_r   <= {ADDR_W{1'b0}};
      req_wdata_r  <= {DATA_W{1'b0}};
      miss_r       <= 1'b0;
      victim_r     <= {WAY_W{1'b0}};
      cnt_r        <= {OFF_W{1'b0}};
      resp_valid_r <= 1'b0;
      resp_hit_r   <= 1'b0;
      resp_rdata_r <= {DATA_W{1'b0}};
      mem_valid_r  <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {DATA_W{1'b0}};
      for (int s = 0; s < SETS; s++) begin
        valid_r[s] <= {WAYS{1'b0}};
        dirty_r[s] <= {WAYS{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
          age_r[s][w] <= WAY_W'(w);
        end
      end
    end else begin
      resp_valid_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (cpu.cpu_req_valid) begin
            req_we_r    <= cpu.cpu_req_we;
            req_addr_r  <= cpu.cpu_req_addr;
            req_wdata_r <= cpu.cpu_req_wdata;
            miss_r      <= 1'b0;
            state_r     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit_s) begin
            // Writes also return the word they overwrite.
            resp_rdata_r <= data_r[idx_s][hit_way_s][off_s];
            if (req_we_r) begin
              dirty_r[idx_s][hit_way_s] <= 1'b1;
            end
            for (int w = 0; w < WAYS; w++) begin
              if (WAY_W'(w) == hit_way_s) begin
                age_r[idx_s][w] <= AGE_MAX;
              end else if (age_r[idx_s][w] > age_r[idx_s][hit_way_s]) begin
                age_r[idx_s][w] <= age_r[idx_s][w] - 1'b1;
              end
            end
            resp_valid_r <= 1'b1;
            resp_hit_r   <= !miss_r;
            state_r      <= S_RESPOND;
          end else begin
            miss_r      <= 1'b1;
            victim_r    <= victim_s;
            cnt_r       <= {OFF_W{1'b0}};
            mem_valid_r <= 1'b1;
            if (valid_r[idx_s][victim_s] && dirty_r[idx_s][victim_s]) begin
              mem_we_r    <= 1'b1;
              mem_addr_r  <= {tag_r[idx_s][victim_s], idx_s, {OFF_W{1'b0}}};
              mem_wdata_r <= data_r[idx_s][victim_s][0];
              state_r     <= S_WRITEBACK;
            end else begin
              mem_we_r   <= 1'b0;
              mem_addr_r <= {tag_s, idx_s, {OFF_W{1'b0}}};
              state_r    <= S_REFILL;
            end
          end
        end
        S_WRITEBACK: begin
          if (ack_s) begin
            if (cnt_r == CNT_LAST) begin
              cnt_r      <= {OFF_W{1'b0}};
              mem_we_r   <= 1'b0;
              mem_addr_r <= {tag_s, idx_s, {OFF_W{1'b0}}};
              state_r    <= S_REFILL;
            end else begin
              cnt_r       <= cnt_nxt_s;
              mem_addr_r  <= {tag_r[idx_s][victim_r], idx_s, cnt_nxt_s};
              mem_wdata_r <= data_r[idx_s][victim_r][cnt_nxt_s];
            end
          end
        end
        S_REFILL: begin
          if (ack_s) begin
            if (cnt_r == CNT_LAST) begin
              cnt_r                    <= {OFF_W{1'b0}};
              mem_valid_r              <= 1'b0;
              valid_r[idx_s][victim_r] <= 1'b1;
              dirty_r[idx_s][victim_r] <= 1'b0;
              state_r                  <= S_LOOKUP;
            end else begin
              cnt_r      <= cnt_nxt_s;
              mem_addr_r <= {tag_s, idx_s, cnt_nxt_s};
            end
          end
        end
        S_RESPOND: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (state_r == S_LOOKUP && hit_s && req_we_r) begin
      data_r[idx_s][hit_way_s][off_s] <= req_wdata_r;
    end else if (state_r == S_REFILL && ack_s) begin
      data_r[idx_s][victim_r][cnt_r] <= mem.mem_rdata;
      if (cnt_r == CNT_LAST) begin
        tag_r[idx_s][victim_r] <= tag_s;
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_r;
  logic [31:0] miss_count_r;

  // Statistics counters, bumped once per completed request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
    end else if (state_r == S_RESPOND) begin
      if (miss_r) begin
        miss_count_r <= miss_count_r + 32'd1;
      end else begin
        hit_count_r <= hit_count_r + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_r;
  assign miss_count = miss_count_r;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

  assign cpu.cpu_req_ready  = (state_r == S_IDLE);
  assign cpu.cpu_resp_valid = resp_valid_r;
  assign cpu.cpu_resp_rdata = resp_rdata_r;
  assign cpu.cpu_resp_hit   = resp_hit_r;
  assign mem.mem_req_valid  = mem_valid_r;
  assign mem.mem_req_we     = mem_we_r;
  assign mem.mem_req_addr   = mem_addr_r;
  assign mem.mem_req_wdata  = mem_wdata_r;
endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache: refill, hit, write-back eviction, ack stalls, mid-burst reset.
module tb_set_assoc_cache;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  cache_cpu_if #(.ADDR_W(16), .DATA_W(32)) cpu_bus ();
  cache_mem_if #(.ADDR_W(16), .DATA_W(32)) mem_bus ();

  set_assoc_cache dut (
    .clk        (clk),
    .reset      (reset),
    .cpu        (cpu_bus),
    .mem        (mem_bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

`ifdef CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int          pass_cnt = 0;
  int          check_cnt = 0;
  logic [31:0] mem_model [0:65535];
  logic        log_we    [0:31];
  logic [15:0] log_addr  [0:31];
  logic [31:0] log_wd    [0:31];
  int          log_n;
  logic [31:0] r_rdata;
  logic        r_hit;
  int          r_cyc;
  logic        r_done;
  logic [31:0] wb_exp [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request from a negedge in IDLE and act as the memory until the response.
  task automatic access(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                        input int stall, input int abort_word);
    int          stall_left = stall;
    logic        snap_ok = 1'b0;
    logic [15:0] s_addr = 16'h0000;
    logic        s_we = 1'b0;
    log_n  = 0;
    r_done = 1'b0;
    r_cyc  = 0;
    cpu_bus.cpu_req_valid = 1'b1;
    cpu_bus.cpu_req_we    = we;
    cpu_bus.cpu_req_addr  = addr;
    cpu_bus.cpu_req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    cpu_bus.cpu_req_valid = 1'b0;
    for (int c = 1; c <= 200 && !r_done; c++) begin
      if (cpu_bus.cpu_resp_valid) begin
        r_done  = 1'b1;
        r_cyc   = c;
        r_rdata = cpu_bus.cpu_resp_rdata;
        r_hit   = cpu_bus.cpu_resp_hit;
      end else begin
        mem_bus.mem_ack = 1'b0;
        if (mem_bus.mem_req_valid) begin
          if (abort_word >= 0 && !mem_bus.mem_req_we &&
              mem_bus.mem_req_addr[1:0] == abort_word[1:0]) begin
            reset = 1'b0;
            #1;
            chk("abort_mem_valid", 32'(mem_bus.mem_req_valid), 32'd0);
            chk("abort_mem_addr", 32'(mem_bus.mem_req_addr), 32'd0);
            chk("abort_ready", 32'(cpu_bus.cpu_req_ready), 32'd1);
            return;
          end
          if (stall_left > 0 && !mem_bus.mem_req_we) begin
            if (!snap_ok) begin
              snap_ok = 1'b1;
              s_addr  = mem_bus.mem_req_addr;
              s_we    = mem_bus.mem_req_we;
            end else begin
              chk("stall_valid", 32'(mem_bus.mem_req_valid), 32'd1);
              chk("stall_addr", 32'(mem_bus.mem_req_addr), 32'(s_addr));
              chk("stall_we", 32'(mem_bus.mem_req_we), 32'(s_we));
            end
            stall_left--;
          end else begin
            mem_bus.mem_ack   = 1'b1;
            mem_bus.mem_rdata = mem_model[mem_bus.mem_req_addr];
            if (log_n < 32) begin
              log_we[log_n]   = mem_bus.mem_req_we;
              log_addr[log_n] = mem_bus.mem_req_addr;
              log_wd[log_n]   = mem_bus.mem_req_wdata;
            end
            log_n++;
            if (mem_bus.mem_req_we) begin
              mem_model[mem_bus.mem_req_addr] = mem_bus.mem_req_wdata;
            end
          end
        end
        @(posedge clk);
        @(negedge clk);
      end
    end
    mem_bus.mem_ack = 1'b0;
    chk("resp_seen", 32'(r_done), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("ready_after", 32'(cpu_bus.cpu_req_ready), 32'd1);
  endtask

  // Checks a clean 4-word refill burst of the line starting at base.
  task automatic chk_refill(input string tag, input logic [15:0] base, input int first);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_we%0d", tag, i), 32'(log_we[first+i]), 32'd0);
      chk($sformatf("%s_addr%0d", tag, i), 32'(log_addr[first+i]), 32'(base) + 32'(i));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 65536; a++) mem_model[a] = {16'hB000, 16'(a)};
    mem_model[16'h0040] = 32'h0000_00A0;
    mem_model[16'h0041] = 32'h0000_00A1;
    mem_model[16'h0042] = 32'h0000_00A2;
    mem_model[16'h0043] = 32'h0000_00A3;
    wb_exp = '{32'h0000_00A0, 32'hDEAD_BEEF, 32'h0000_00A2, 32'h0000_00A3};
    cpu_bus.cpu_req_valid = 1'b0;
    cpu_bus.cpu_req_we    = 1'b0;
    cpu_bus.cpu_req_addr  = 16'h0000;
    cpu_bus.cpu_req_wdata = 32'h0000_0000;
    mem_bus.mem_ack       = 1'b0;
    mem_bus.mem_rdata     = 32'h0000_0000;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cpu_bus.cpu_req_ready), 32'd1);
    chk("rst_resp_valid", 32'(cpu_bus.cpu_resp_valid), 32'd0);
    chk("rst_resp_hit", 32'(cpu_bus.cpu_resp_hit), 32'd0);
    chk("rst_resp_rdata", cpu_bus.cpu_resp_rdata, 32'd0);
    chk("rst_mem_valid", 32'(mem_bus.mem_req_valid), 32'd0);
    chk("rst_mem_we", 32'(mem_bus.mem_req_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_bus.mem_req_addr), 32'd0);
    chk("rst_mem_wdata", mem_bus.mem_req_wdata, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Cold read miss: clean refill, response 7 cycles after accept.
    access(1'b0, 16'h0040, 32'd0, 0, -1);
    chk("rd40_words", 32'(log_n), 32'd4);
    chk_refill("rd40", 16'h0040, 0);
    chk("rd40_rdata", r_rdata, 32'h0000_00A0);
    chk("rd40_hit", 32'(r_hit), 32'd0);
    chk("rd40_cyc", 32'(r_cyc), 32'd7);
    chk("rd40_misses", miss_count, STATS ? 32'd1 : 32'd0);
    chk("rd40_hits", hit_count, 32'd0);

    // Read hit: no memory traffic, response in cycle 2.
    access(1'b0, 16'h0042, 32'd0, 0, -1);
    chk("rd42_words", 32'(log_n), 32'd0);
    chk("rd42_rdata", r_rdata, 32'h0000_00A2);
    chk("rd42_hit", 32'(r_hit), 32'd1);
    chk("rd42_cyc", 32'(r_cyc), 32'd2);
    chk("rd42_hits", hit_count, STATS ? 32'd1 : 32'd0);

    // Write hit returns the overwritten word.
    access(1'b1, 16'h0041, 32'hDEAD_BEEF, 0, -1);
    chk("wr41_words", 32'(log_n), 32'd0);
    chk("wr41_rdata", r_rdata, 32'h0000_00A1);
    chk("wr41_hit", 32'(r_hit), 32'd1);

    // Fill ways 1..3 of set 0x10 with no write-back.
    access(1'b0, 16'h0140, 32'd0, 0, -1);
    chk("rd140_words", 32'(log_n), 32'd4);
    chk_refill("rd140", 16'h0140, 0);
    chk("rd140_rdata", r_rdata, 32'hB000_0140);
    access(1'b0, 16'h0240, 32'd0, 0, -1);
    chk("rd240_words", 32'(log_n), 32'd4);
    chk_refill("rd240", 16'h0240, 0);
    access(1'b0, 16'h0340, 32'd0, 0, -1);
    chk("rd340_words", 32'(log_n), 32'd4);
    chk_refill("rd340", 16'h0340, 0);
    chk("rd340_hit", 32'(r_hit), 32'd0);

    // Set full: way 0 (LRU age 0, dirty) is written back before the refill.
    access(1'b0, 16'h0440, 32'd0, 0, -1);
    chk("rd440_words", 32'(log_n), 32'd8);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wb_we%0d", i), 32'(log_we[i]), 32'd1);
      chk($sformatf("wb_addr%0d", i), 32'(log_addr[i]), 32'h0040 + 32'(i));
      chk($sformatf("wb_data%0d", i), log_wd[i], wb_exp[i]);
    end
    chk_refill("rd440", 16'h0440, 4);
    chk("rd440_rdata", r_rdata, 32'hB000_0440);
    chk("rd440_hit", 32'(r_hit), 32'd0);
    chk("rd440_cyc", 32'(r_cyc), 32'd11);

    // Five-cycle ack stall on the first refill word (victim way 1 is clean).
    access(1'b0, 16'h0541, 32'd0, 5, -1);
    chk("rd541_words", 32'(log_n), 32'd4);
    chk_refill("rd541", 16'h0540, 0);
    chk("rd541_rdata", r_rdata, 32'hB000_0541);
    chk("rd541_cyc", 32'(r_cyc), 32'd12);

    // Reset while the second refill word is outstanding.
    access(1'b0, 16'h0640, 32'd0, 0, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(cpu_bus.cpu_req_ready), 32'd1);
    chk("post_rst_mem_valid", 32'(mem_bus.mem_req_valid), 32'd0);

    // All lines invalid again: 0x0042 misses and refetches the written-back line.
    access(1'b0, 16'h0042, 32'd0, 0, -1);
    chk("rr42_words", 32'(log_n), 32'd4);
    chk_refill("rr42", 16'h0040, 0);
    chk("rr42_rdata", r_rdata, 32'h0000_00A2);
    chk("rr42_hit", 32'(r_hit), 32'd0);
    access(1'b0, 16'h0041, 32'd0, 0, -1);
    chk("rr41_rdata", r_rdata, 32'hDEAD_BEEF);
    chk("rr41_hit", 32'(r_hit), 32'd1);
    chk("rr_misses", miss_count, STATS ? 32'd1 : 32'd0);
    chk("rr_hits", hit_count, STATS ? 32'd1 : 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
